// File: rtl/uart_rx.sv
// 8N1 (or 8E1 with UART_RX_PARITY_EN) serial receiver with mid-bit sampling,
// a ready/acknowledge output register and framing/parity/overrun flags.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       Serial_In,
    input  logic       Read_Ack,
    output logic [7:0] Data_Out,
    output logic       Data_Ready,
    output logic       Busy,
    output logic       Framing_Error,
    output logic       Parity_Error,
    output logic       Overrun
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    // Stop-sample outcome, registered so the outputs update one edge later.
    logic            ev_good_q, ev_good_d;
    logic            ev_ferr_q, ev_ferr_d;
    logic [7:0]      data_out_q;
    logic            data_ready_q, framing_error_q, overrun_q;
`ifdef UART_RX_PARITY_EN
    logic            par_err_q, par_err_d;
    logic            ev_perr_q, ev_perr_d;
    logic            parity_error_q;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        ev_good_d = 1'b0;
        ev_ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
        ev_perr_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    par_err_d = ^{shift_q, rx_s};
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ev_ferr_d = 1'b1;
                        state_d   = StWaitIdle;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        ev_perr_d = par_err_q;
                        ev_good_d = !par_err_q;
`else
                        ev_good_d = 1'b1;
`endif
                        state_d   = StIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            sync_q    <= 2'b11;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            ev_good_q <= 1'b0;
            ev_ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
            ev_perr_q <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], Serial_In};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ev_good_q <= ev_good_d;
            ev_ferr_q <= ev_ferr_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
            ev_perr_q <= ev_perr_d;
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            data_out_q      <= 8'h00;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q  <= 1'b0;
`endif
        end else begin
            framing_error_q <= ev_ferr_q;
`ifdef UART_RX_PARITY_EN
            parity_error_q  <= ev_perr_q;
`endif
            if (ev_good_q) begin
                data_out_q   <= shift_q;
                data_ready_q <= 1'b1;
                // An ack landing with the new byte leaves Overrun untouched.
                if (data_ready_q && !Read_Ack) overrun_q <= 1'b1;
            end else if (Read_Ack && data_ready_q) begin
                data_ready_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
        end
    end

    assign Data_Out      = data_out_q;
    assign Data_Ready    = data_ready_q;
    assign Busy          = (state_q != StIdle);
    assign Framing_Error = framing_error_q;
    assign Overrun       = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign Parity_Error  = parity_error_q;
`else
    assign Parity_Error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT = 16; expected bytes go through a scoreboard.
module tb_uart_rx;
    localparam int unsigned Cpb = 16;
`ifdef UART_RX_PARITY_EN
    localparam int ParBits = 1;
`else
    localparam int ParBits = 0;
`endif
    // Line falls at edge E: rx_s low after E+2, T0 = E+3, stop sample T0+H+(9+ParBits)*Cpb.
    localparam int ExpLat = 3 + Cpb / 2 + (9 + ParBits) * Cpb + 1;

    logic       CLOCK_50;
    logic       Reset;
    logic       Serial_In;
    logic       Read_Ack;
    logic [7:0] Data_Out;
    logic       Data_Ready;
    logic       Busy;
    logic       Framing_Error;
    logic       Parity_Error;
    logic       Overrun;

    uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
        .CLOCK_50     (CLOCK_50),
        .Reset        (Reset),
        .Serial_In    (Serial_In),
        .Read_Ack     (Read_Ack),
        .Data_Out     (Data_Out),
        .Data_Ready   (Data_Ready),
        .Busy         (Busy),
        .Framing_Error(Framing_Error),
        .Parity_Error (Parity_Error),
        .Overrun      (Overrun)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         frame_cyc = 0;
    int         rise_cyc = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_loads = 0;
    bit         busy_seen = 0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_q[$];

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard monitor: a load is a Data_Ready rise or a new byte while still ready.
    always @(negedge CLOCK_50) begin
        if (!Reset) begin
            if (Framing_Error) n_ferr++;
            if (Parity_Error) n_perr++;
            if (Busy) busy_seen = 1'b1;
            if (Data_Ready && (!prev_ready || Data_Out != prev_data)) begin
                if (!prev_ready) rise_cyc = cyc;
                n_loads++;
                check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("data_out", 32'(Data_Out), 32'(exp_q.pop_front()));
            end
        end
        prev_ready = Data_Ready;
        prev_data  = Data_Out;
    end

    task automatic idle(input int n);
        Serial_In = 1'b1;
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic bit_period(input logic v);
        Serial_In = v;
        repeat (Cpb) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        @(posedge CLOCK_50);
        #1;
        frame_cyc = cyc;
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_period(par_bit);
`else
        if (par_bit) Serial_In = 1'b1;
`endif
        bit_period(stop_bit);
        Serial_In = 1'b1;
    endtask

    task automatic wait_ready(input int budget);
        int k;
        k = 0;
        while (!Data_Ready && k < budget) begin
            @(negedge CLOCK_50);
            k++;
        end
        check("ready_timeout", 32'(Data_Ready), 32'd1);
    endtask

    task automatic pulse_ack();
        @(posedge CLOCK_50);
        #1;
        Read_Ack = 1'b1;
        @(posedge CLOCK_50);
        #1;
        Read_Ack = 1'b0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ferr0;
        Reset = 1'b1;
        Serial_In = 1'b1;
        Read_Ack = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_data_out", 32'(Data_Out), 32'h00);
        check("rst_ready", 32'(Data_Ready), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ferr", 32'(Framing_Error), 32'd0);
        check("rst_perr", 32'(Parity_Error), 32'd0);
        check("rst_overrun", 32'(Overrun), 32'd0);
        @(posedge CLOCK_50);
        #1;
        Reset = 1'b0;
        idle(5);

        // Frame 0xA5, ack two cycles after Data_Ready rises
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, ^8'hA5);
            begin
                wait_ready(400);
                @(posedge CLOCK_50);
                #1;
                Read_Ack = 1'b1;
                @(posedge CLOCK_50);
                #1;
                Read_Ack = 1'b0;
                @(negedge CLOCK_50);
                check("ack_clears_ready", 32'(Data_Ready), 32'd0);
            end
        join
        check("ready_latency", 32'(rise_cyc - frame_cyc), 32'(ExpLat));
        check("a5_overrun", 32'(Overrun), 32'd0);
        check("a5_ferr_cnt", 32'(n_ferr), 32'd0);
        check("a5_perr_cnt", 32'(n_perr), 32'd0);
        idle(10);

        // 5-cycle low glitch
        busy_seen = 1'b0;
        Serial_In = 1'b0;
        repeat (5) @(posedge CLOCK_50);
        #1;
        idle(40);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_idle", 32'(Busy), 32'd0);
        check("glitch_ready", 32'(Data_Ready), 32'd0);
        check("glitch_data", 32'(Data_Out), 32'hA5);

        // Framing error on 0x3C, then a good 0x55
        ferr0 = n_ferr;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        idle(20);
        check("ferr_pulses", 32'(n_ferr - ferr0), 32'd1);
        check("ferr_ready", 32'(Data_Ready), 32'd0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, ^8'h55);
        idle(4);
        check("f55_ready", 32'(Data_Ready), 32'd1);
        pulse_ack();
        idle(10);

        // Back-to-back 0x11, 0x22 without ack: overrun
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        idle(4);
        check("ovr_data", 32'(Data_Out), 32'h22);
        check("ovr_ready", 32'(Data_Ready), 32'd1);
        check("ovr_flag", 32'(Overrun), 32'd1);
        pulse_ack();
        check("ovr_ack_ready", 32'(Data_Ready), 32'd0);
        check("ovr_ack_flag", 32'(Overrun), 32'd0);
        idle(10);

        // Reset in the middle of data bit 4 of 0xFF, then 0x81
        ferr0 = n_ferr + n_perr;
        @(posedge CLOCK_50);
        #1;
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(1'b1);
        Serial_In = 1'b1;
        repeat (Cpb / 2) @(posedge CLOCK_50);
        #1;
        Reset = 1'b1;
        #1;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_data", 32'(Data_Out), 32'h00);
        repeat (3) @(posedge CLOCK_50);
        #1;
        Reset = 1'b0;
        idle(30);
        check("midrst_ready", 32'(Data_Ready), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, ^8'h81);
        idle(4);
        check("f81_ready", 32'(Data_Ready), 32'd1);
        check("midrst_no_err", 32'(n_ferr + n_perr - ferr0), 32'd0);
        pulse_ack();
        idle(10);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: parity bit 1 is correct, 0 is an error
        ferr0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        check("par_pulses", 32'(n_perr - ferr0), 32'd1);
        check("par_ready", 32'(Data_Ready), 32'd0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        check("par_good_ready", 32'(Data_Ready), 32'd1);
        check("par_good_data", 32'(Data_Out), 32'h07);
        pulse_ack();
`else
        check("no_parity_pulses", 32'(n_perr), 32'd0);
`endif
        idle(10);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("load_count", 32'(n_loads), 32'(5 + ParBits));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
